pipe_hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage miniRV core.
- Drives hold, flush and bubble controls for the PC and the four inter-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Handles three events: RAW data hazards against in-flight register writes, taken-branch/jump flushes, and multi-cycle DRAM waits via a req/ack handshake.
- Keeps saturating performance counters for stall and flush activity.

---
 rtl/pipe_hazard_ctrl_if.sv | 58 +++++
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake/control bundle between the miniRV datapath and pipe_hazard_ctrl.
// master = datapath side (drives hazard inputs), slave = the controller.
// Optional forwarding selects exist only when PIPE_CTRL_FWD_EN is defined.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       ex_wb_addr;
    logic             ex_rf_wen;
    logic [1:0]       ex_wb_sel;
    logic [4:0]       mem_wb_addr;
    logic             mem_rf_wen;
    logic [4:0]       wb_wb_addr;
    logic             wb_rf_wen;
    logic             ex_branch_taken;
    logic             dram_req;
    logic             dram_ack;

    logic             pc_hold;
    logic             buf1_hold;
    logic             buf1_flush;
    logic             buf2_hold;
    logic             buf2_flush;
    logic             buf3_hold;
    logic             buf4_bubble;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
`ifdef PIPE_CTRL_FWD_EN
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
`endif

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_wb_addr, ex_rf_wen, ex_wb_sel, mem_wb_addr, mem_rf_wen,
               wb_wb_addr, wb_rf_wen, ex_branch_taken, dram_req, dram_ack,
        input  pc_hold, buf1_hold, buf1_flush, buf2_hold, buf2_flush,
               buf3_hold, buf4_bubble, mem_err, stall_cycles, flush_count
`ifdef PIPE_CTRL_FWD_EN
      , input  fwd_a, fwd_b
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_wb_addr, ex_rf_wen, ex_wb_sel, mem_wb_addr, mem_rf_wen,
               wb_wb_addr, wb_rf_wen, ex_branch_taken, dram_req, dram_ack,
        output pc_hold, buf1_hold, buf1_flush, buf2_hold, buf2_flush,
               buf3_hold, buf4_bubble, mem_err, stall_cycles, flush_count
`ifdef PIPE_CTRL_FWD_EN
      , output fwd_a, fwd_b
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage miniRV core: hold/flush/bubble controls
// for the PC and the four inter-stage buffers, DRAM wait with timeout, and
// saturating stall/flush counters.
// Optional feature macro: PIPE_CTRL_FWD_EN (EX/MEM/WB forwarding selects,
// stall only on load-use).
module pipe_hazard_ctrl #(
    parameter logic [1:0] WB_SEL_LOAD = 2'b01,
    parameter int         MEM_TIMEOUT = 16,
    parameter int         CNT_W       = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, STALL, MEMWAIT} state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    logic rs1_ex, rs1_mem, rs1_wb, rs2_ex, rs2_mem, rs2_wb;
    logic data_haz, mem_wait, take_branch, data_stall;
    logic [WAIT_W-1:0] wait_base;

    // A source hazards against a stage only if it is really read, is not x0,
    // and the stage is actually going to write that register.
    function automatic logic src_hit(input logic used, input logic [4:0] rs,
                                     input logic [4:0] dst, input logic wen);
        return used && (rs != 5'd0) && (rs == dst) && wen;
    endfunction

    // Per-source, per-stage register matches and the resulting data hazard.
    always_comb begin
        rs1_ex  = src_hit(bus.id_rs1_used, bus.id_rs1, bus.ex_wb_addr,  bus.ex_rf_wen);
        rs1_mem = src_hit(bus.id_rs1_used, bus.id_rs1, bus.mem_wb_addr, bus.mem_rf_wen);
        rs1_wb  = src_hit(bus.id_rs1_used, bus.id_rs1, bus.wb_wb_addr,  bus.wb_rf_wen);
        rs2_ex  = src_hit(bus.id_rs2_used, bus.id_rs2, bus.ex_wb_addr,  bus.ex_rf_wen);
        rs2_mem = src_hit(bus.id_rs2_used, bus.id_rs2, bus.mem_wb_addr, bus.mem_rf_wen);
        rs2_wb  = src_hit(bus.id_rs2_used, bus.id_rs2, bus.wb_wb_addr,  bus.wb_rf_wen);
`ifdef PIPE_CTRL_FWD_EN
        // Only a load still in EX cannot be bypassed in time.
        data_haz = (rs1_ex || rs2_ex) && (bus.ex_wb_sel == WB_SEL_LOAD);
`else
        data_haz = rs1_ex || rs1_mem || rs1_wb || rs2_ex || rs2_mem || rs2_wb;
`endif
    end

`ifdef PIPE_CTRL_FWD_EN
    // Forward selects: the youngest producer (MEM) wins over WB.
    always_comb begin
        bus.fwd_a = 2'b00;
        bus.fwd_b = 2'b00;
        if (rst) begin
            if (rs1_mem)     bus.fwd_a = 2'b01;
            else if (rs1_wb) bus.fwd_a = 2'b10;
            if (rs2_mem)     bus.fwd_b = 2'b01;
            else if (rs2_wb) bus.fwd_b = 2'b10;
        end
    end
`else
    logic unused_wb_sel;
    assign unused_wb_sel = ^bus.ex_wb_sel;
`endif

    // Event priority (mem wait > branch > data hazard) and next-state logic.
    always_comb begin
        // NOTE: every always_comb target gets a default first, so no latch is inferred.
        state_d        = RUN;
        wait_cnt_d     = '0;
        mem_err_d      = mem_err_q;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;

        mem_wait    = bus.dram_req && !bus.dram_ack && !mem_err_q;
        take_branch = bus.ex_branch_taken && !mem_wait;
        data_stall  = data_haz && !mem_wait && !bus.ex_branch_taken;
        // The counter is only meaningful while already waiting.
        wait_base   = (state_q == MEMWAIT) ? wait_cnt_q : '0;

        if (mem_wait) begin
            if (wait_base == WAIT_W'(MEM_TIMEOUT - 1)) begin
                mem_err_d = 1'b1;
            end else begin
                state_d    = MEMWAIT;
                wait_cnt_d = wait_base + 1'b1;
            end
        end else if (data_stall) begin
            state_d = STALL;
        end

        if (take_branch && (flush_count_q != '1)) flush_count_d = flush_count_q + 1'b1;
        if (data_stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
    end

    // Buffer controls; all forced low while reset is asserted.
    always_comb begin
        bus.pc_hold     = rst && (mem_wait || data_stall);
        bus.buf1_hold   = rst && (mem_wait || data_stall);
        bus.buf1_flush  = rst && take_branch;
        bus.buf2_hold   = rst && mem_wait;
        bus.buf2_flush  = rst && (take_branch || data_stall);
        bus.buf3_hold   = rst && mem_wait;
        bus.buf4_bubble = rst && mem_wait;
    end

    assign bus.mem_err      = mem_err_q;
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;

    // State, wait counter, error flag and counters with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
        if (!rst) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a rule-level model checked every
// cycle on the falling edge, plus directed scenarios with literal expectations.
// Honours PIPE_CTRL_FWD_EN when the bundle is built with that macro.
module tb_pipe_hazard_ctrl;
    localparam logic [1:0] LOAD    = 2'b01;
    localparam int         TIMEOUT = 16;
    localparam int         CW      = 16;
    localparam int         SAT     = (1 << CW) - 1;
`ifdef PIPE_CTRL_FWD_EN
    localparam int STALL_BASE = 1;
`else
    localparam int STALL_BASE = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(.WB_SEL_LOAD(LOAD), .MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_stall = 0;
    int m_flush = 0;
    int m_wait_len = 0;
    bit m_err = 0;

    function automatic bit stage_hits(input int stage, input logic [4:0] rs, input logic used);
        logic [4:0] dst;
        logic       wen;
        case (stage)
            0:       begin dst = bus.ex_wb_addr;  wen = bus.ex_rf_wen;  end
            1:       begin dst = bus.mem_wb_addr; wen = bus.mem_rf_wen; end
            default: begin dst = bus.wb_wb_addr;  wen = bus.wb_rf_wen;  end
        endcase
        return used && (rs != 0) && wen && (dst == rs);
    endfunction

    function automatic bit model_haz();
        bit haz = 0;
        bit hit;
        for (int s = 0; s < 3; s++) begin
            hit = stage_hits(s, bus.id_rs1, bus.id_rs1_used) || stage_hits(s, bus.id_rs2, bus.id_rs2_used);
`ifdef PIPE_CTRL_FWD_EN
            if (hit && s == 0 && bus.ex_wb_sel == LOAD) haz = 1;
`else
            if (hit) haz = 1;
`endif
        end
        return haz;
    endfunction

`ifdef PIPE_CTRL_FWD_EN
    function automatic logic [1:0] model_fwd(input logic [4:0] rs, input logic used);
        if (stage_hits(1, rs, used)) return 2'b01;
        if (stage_hits(2, rs, used)) return 2'b10;
        return 2'b00;
    endfunction
`endif

    // Compare DUT against the model every cycle, then advance the model.
    always @(negedge clk) begin
        bit mw, br, dh;
        logic [6:0] exp_ctl, act_ctl;
        mw = rst && bus.dram_req && !bus.dram_ack && !m_err;
        br = rst && !mw && bus.ex_branch_taken;
        dh = rst && !mw && !bus.ex_branch_taken && model_haz();
        exp_ctl = {mw | dh, mw | dh, br, mw, br | dh, mw, mw};
        act_ctl = {bus.pc_hold, bus.buf1_hold, bus.buf1_flush, bus.buf2_hold,
                   bus.buf2_flush, bus.buf3_hold, bus.buf4_bubble};
        check("model_ctl", 32'(act_ctl), 32'(exp_ctl));
        check("model_stall_cycles", 32'(bus.stall_cycles), 32'(m_stall));
        check("model_flush_count", 32'(bus.flush_count), 32'(m_flush));
        check("model_mem_err", 32'(bus.mem_err), 32'(m_err));
`ifdef PIPE_CTRL_FWD_EN
        check("model_fwd_a", 32'(bus.fwd_a), rst ? 32'(model_fwd(bus.id_rs1, bus.id_rs1_used)) : 0);
        check("model_fwd_b", 32'(bus.fwd_b), rst ? 32'(model_fwd(bus.id_rs2, bus.id_rs2_used)) : 0);
`endif
        if (!rst) begin
            m_stall = 0; m_flush = 0; m_wait_len = 0; m_err = 0;
        end else begin
            if (mw) begin
                m_wait_len++;
                if (m_wait_len == TIMEOUT) begin
                    m_err = 1;
                    m_wait_len = 0;
                end
            end else begin
                m_wait_len = 0;
            end
            if (br && m_flush < SAT) m_flush++;
            if (dh && m_stall < SAT) m_stall++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rs1_used = 0; bus.id_rs2_used = 0;
        bus.ex_wb_addr = 0; bus.ex_rf_wen = 0; bus.ex_wb_sel = 0;
        bus.mem_wb_addr = 0; bus.mem_rf_wen = 0; bus.wb_wb_addr = 0; bus.wb_rf_wen = 0;
        bus.ex_branch_taken = 0; bus.dram_req = 0; bus.dram_ack = 0;
    endtask

    // Advance one clock; new inputs are applied just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        // Reset with req and branch asserted: all controls forced low.
        rst = 0; bus.dram_req = 1; bus.ex_branch_taken = 1;
        step(); step();
        #1;
        check("rst_pc_hold", 32'(bus.pc_hold), 0);
        check("rst_buf1_flush", 32'(bus.buf1_flush), 0);
        check("rst_buf4_bubble", 32'(bus.buf4_bubble), 0);
        check("rst_counters", 32'({bus.stall_cycles, bus.flush_count}), 0);
        check("rst_mem_err", 32'(bus.mem_err), 0);
        idle(); rst = 1;
        step(); #1;
        check("run_after_rst", 32'(bus.pc_hold), 0);

`ifdef PIPE_CTRL_FWD_EN
        // lw x3 in EX, ID reads x3: one stall, then WB supplies the value.
        bus.ex_wb_addr = 3; bus.ex_rf_wen = 1; bus.ex_wb_sel = LOAD;
        bus.id_rs1 = 3; bus.id_rs1_used = 1;
        #1; check("ldu_stall", 32'(bus.pc_hold), 1);
        step();
        bus.ex_rf_wen = 0; bus.wb_wb_addr = 3; bus.wb_rf_wen = 1;
        #1; check("ldu_fwd_wb", 32'(bus.fwd_a), 32'(2'b10));
        check("ldu_no_stall", 32'(bus.pc_hold), 0);
        step();
        bus.mem_wb_addr = 3; bus.mem_rf_wen = 1;
        #1; check("alu_fwd_mem", 32'(bus.fwd_a), 32'(2'b01));
        check("alu_no_stall", 32'(bus.pc_hold), 0);
        step();
        idle(); #1;
        check("fwd_stall_cnt", 32'(bus.stall_cycles), 1);
`else
        // RAW on x5 while the producer drains EX -> MEM -> WB.
        bus.id_rs1 = 5; bus.id_rs1_used = 1;
        bus.ex_wb_addr = 5; bus.ex_rf_wen = 1;
        #1; check("raw_ex", 32'({bus.pc_hold, bus.buf1_hold, bus.buf2_flush}), 32'(3'b111));
        step();
        bus.ex_rf_wen = 0; bus.mem_wb_addr = 5; bus.mem_rf_wen = 1;
        #1; check("raw_mem", 32'({bus.pc_hold, bus.buf1_hold, bus.buf2_flush}), 32'(3'b111));
        step();
        bus.mem_rf_wen = 0; bus.wb_wb_addr = 5; bus.wb_rf_wen = 1;
        #1; check("raw_wb", 32'({bus.pc_hold, bus.buf1_hold, bus.buf2_flush}), 32'(3'b111));
        step();
        bus.wb_rf_wen = 0;
        #1; check("raw_done", 32'(bus.pc_hold), 0);
        check("raw_stall_cnt", 32'(bus.stall_cycles), 3);
        // x0 never hazards.
        bus.id_rs1 = 0; bus.ex_wb_addr = 0; bus.ex_rf_wen = 1;
        #1; check("x0_no_stall", 32'(bus.pc_hold), 0);
        step();
        idle();
`endif

        // Branch while a load-use hazard is present: flush wins.
        bus.id_rs2 = 7; bus.id_rs2_used = 1;
        bus.ex_wb_addr = 7; bus.ex_rf_wen = 1; bus.ex_wb_sel = LOAD;
        #1; check("bh_stall", 32'(bus.pc_hold), 1);
        step();
        bus.ex_branch_taken = 1;
        #1; check("bh_flush", 32'({bus.buf1_flush, bus.buf2_flush, bus.pc_hold, bus.buf1_hold}), 32'(4'b1100));
        step();
        idle(); #1;
        check("bh_flush_cnt", 32'(bus.flush_count), 1);
        check("bh_stall_cnt", 32'(bus.stall_cycles), 32'(STALL_BASE + 1));

        // DRAM wait of 4 cycles with a taken branch frozen in EX.
        bus.dram_req = 1; bus.ex_branch_taken = 1;
        for (int i = 0; i < 4; i++) begin
            #1; check("dw_freeze", 32'({bus.pc_hold, bus.buf2_hold, bus.buf3_hold, bus.buf4_bubble, bus.buf1_flush}), 32'(5'b11110));
            step();
        end
        bus.dram_ack = 1;
        #1; check("dw_ack_flush", 32'({bus.buf1_flush, bus.pc_hold, bus.buf4_bubble}), 32'(3'b100));
        step();
        idle(); #1;
        check("dw_flush_cnt", 32'(bus.flush_count), 2);
        // Single-cycle ack: no stall at all.
        bus.dram_req = 1; bus.dram_ack = 1;
        #1; check("dw_single", 32'({bus.pc_hold, bus.buf4_bubble}), 0);
        step();
        idle();

        // Timeout: 16 frozen cycles, then mem_err and no further waits.
        bus.dram_req = 1;
        for (int i = 0; i < TIMEOUT; i++) begin
            #1; check("to_freeze", 32'({bus.pc_hold, bus.mem_err}), 32'(2'b10));
            step();
        end
        #1; check("to_err", 32'({bus.mem_err, bus.pc_hold, bus.buf4_bubble}), 32'(3'b100));
        step();
        #1; check("to_masked", 32'(bus.pc_hold), 0);
        rst = 0;
        step();
        rst = 1;
        #1; check("to_rst_clears", 32'({bus.mem_err, bus.pc_hold}), 32'(2'b01));
        step();
        idle();

        // Stall counter saturation.
        bus.id_rs1 = 9; bus.id_rs1_used = 1;
        bus.ex_wb_addr = 9; bus.ex_rf_wen = 1; bus.ex_wb_sel = LOAD;
        for (int i = 0; i < SAT + 4; i++) step();
        #1; check("sat_stall", 32'(bus.stall_cycles), 32'(SAT));
        step();
        idle(); #1;
        check("sat_hold", 32'(bus.stall_cycles), 32'(SAT));
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
